// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-supply end of the SISC datapath.
//
// Owns the PC, computes branch targets, fetches instructions from an
// instruction memory over a req/ack handshake and drives the 32-bit `ir`
// consumed by the core.
//
// Ports:
//   clk, rst_f                 clock, synchronous active-high reset
//   pc_rst, pc_write, pc_sel,  ctrl strobes for the PC
//   br_sel, br_imm             branch target select / offset-or-address
//   ir_load                    start a fetch at the current PC
//   ir, ir_valid               instruction register and its valid flag
//   pc_out                     current PC
//   busy                       fetch in flight
//   fetch_err                  one-cycle pulse when a fetch times out
//   imem_req/addr/rdata/ack    instruction memory read handshake
module fetch_unit #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15   // 1..255
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              pc_rst,
  input  logic              pc_write,
  input  logic              pc_sel,
  input  logic              br_sel,
  input  logic [ADDR_W-1:0] br_imm,
  input  logic              ir_load,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ir_valid,
  output logic              busy,
  output logic              fetch_err,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [7:0]        TO_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_q, br_addr;
  logic [DATA_W-1:0] ir_q, ir_n;
  logic              vld_q, vld_n;
  logic              req_q, req_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [7:0]        cnt_q, cnt_n;
  logic              err_q, err_n;

  // Branch target; both forms wrap modulo 2^ADDR_W.
  assign br_addr = br_sel ? br_imm : (pc_q + ADDR_W'(1) + br_imm);

  // PC is independent of the fetch FSM: a fetch in flight keeps the
  // address it latched, so PC may move freely underneath it.
  always_ff @(posedge clk) begin
    if (rst_f)         pc_q <= RST_PC;
    else if (pc_rst)   pc_q <= RST_PC;
    else if (pc_write) pc_q <= pc_sel ? br_addr : (pc_q + ADDR_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state  <= IDLE;
      ir_q   <= '0;
      vld_q  <= 1'b0;
      req_q  <= 1'b0;
      addr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      ir_q   <= ir_n;
      vld_q  <= vld_n;
      req_q  <= req_n;
      addr_q <= addr_n;
      cnt_q  <= cnt_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    ir_n    = ir_q;
    vld_n   = vld_q;
    req_n   = req_q;
    addr_n  = addr_q;
    cnt_n   = cnt_q;
    err_n   = 1'b0;
    case (state)
      // DONE behaves like IDLE so back-to-back fetches need no bubble.
      // The fetch address is the PC before any same-cycle pc_write.
      IDLE, DONE: begin
        state_n = IDLE;
        if (ir_load) begin
          state_n = REQ;
          req_n   = 1'b1;
          addr_n  = pc_q;
          vld_n   = 1'b0;
          cnt_n   = '0;
        end
      end
      REQ: begin
        // Ack is checked first so an ack on the timeout cycle still wins.
        if (imem_ack) begin
          ir_n    = imem_rdata;
          vld_n   = 1'b1;
          req_n   = 1'b0;
          state_n = DONE;
        end else if (cnt_q == TO_CNT) begin
          ir_n    = '0;          // deliver a NOP so the core keeps going
          vld_n   = 1'b1;
          err_n   = 1'b1;
          req_n   = 1'b0;
          state_n = DONE;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pc_out    = pc_q;
  assign ir        = ir_q;
  assign ir_valid  = vld_q;
  assign imem_req  = req_q;
  assign busy      = req_q;
  assign imem_addr = addr_q;
  assign fetch_err = err_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-supply end of the SISC datapath. Owns the PC, computes branch targets, issues read requests to an instruction memory over a req/ack handshake, and drives the 32-bit `ir` that the sisc core consumes.
- Driven by the ctrl strobes `pc_rst`, `pc_write`, `pc_sel`, `br_sel` and `ir_load`.
- Replaces the testbench-driven `ir` in the part 2 top level.

Parameters:
- ADDR_W, 16, PC / instruction address width.
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value after reset or `pc_rst`.
- TIMEOUT, 15, max cycles to wait for `imem_ack` before aborting a fetch (range 1..255).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_f  in  1  reset; synchronous, active-high (1 = reset).
- pc_rst  in  1  ctrl: load PC with RESET_PC.
- pc_write  in  1  ctrl: update PC this cycle.
- pc_sel  in  1  0 = PC+1, 1 = branch target.
- br_sel  in  1  0 = relative target, 1 = absolute target.
- br_imm  in  16  branch offset/address, `ir[15:0]` of the current instruction.
- ir_load  in  1  ctrl: start a fetch at the current PC.
- ir  out  32  instruction register.
- pc_out  out  16  current PC.
- ir_valid  out  1  `ir` holds a completed fetch.
- busy  out  1  fetch in flight.
- fetch_err  out  1  one-cycle pulse on timeout.
- imem_req  out  1  memory read request.
- imem_addr  out  16  memory read address.
- imem_rdata  in  32  memory read data.
- imem_ack  in  1  memory data valid.

Behaviour:
- **Reset** (`rst_f`=1, synchronous, overrides everything):
  - PC=RESET_PC, ir=0, ir_valid=0, busy=0, fetch_err=0, imem_req=0, imem_addr=0.
  - State = IDLE; timeout counter = 0.
  - A reset asserted mid-fetch drops `imem_req` the next cycle. Any later `imem_ack` is ignored.
- **Branch target** (combinational, 16-bit, wraps modulo 2^16):
  - br_addr = br_sel ? br_imm : (pc_out + 1 + br_imm).
- **PC update** (priority order):
  - `pc_rst` → RESET_PC.
  - else `pc_write` & !`pc_sel` → pc_out+1 (0xFFFF wraps to 0x0000).
  - else `pc_write` & `pc_sel` → br_addr.
  - else hold.
- PC updates are legal in any FSM state. An in-flight fetch keeps its latched address.
- **FSM states:** IDLE, REQ, DONE.
- **IDLE:**
  - `ir_load`=1 → latch imem_addr=pc_out, imem_req=1, busy=1, ir_valid=0, counter=0, go to REQ.
  - If `pc_write` occurs in the same cycle, the OLD PC is fetched.
- **REQ:**
  - `imem_req` stays high.
  - `imem_ack`=1 → ir=imem_rdata, ir_valid=1, imem_req=0, busy=0, go to DONE. Minimum latency: ack in the first REQ cycle puts `ir` valid on the next edge.
  - Otherwise counter+1. At counter==TIMEOUT with no ack → ir=0x00000000 (NOP), ir_valid=1, fetch_err pulse for 1 cycle, imem_req=0, go to DONE.
  - Ack and timeout in the same cycle → ack wins, no error.
  - `ir_load` while in REQ is ignored.
- **DONE:**
  - Holds `ir`.
  - Next cycle returns to IDLE.
  - `ir_load` in DONE is treated as in IDLE: a back-to-back fetch is allowed.
- `imem_ack` while not in REQ is ignored.
- `ir` and `ir_valid` change only on fetch completion, timeout, reset, or a new fetch start (ir_valid→0).
- `pc_rst` does not abort an in-flight fetch; only `rst_f` does.

Test Plan:
- **Reset:** `rst_f`=1 for 2 cycles while imem_ack=1 → pc_out=0x0000, ir=0, ir_valid=0, imem_req=0.
- **Sequential fetch:** memory with 1-cycle ack returning 0x11230004 @0, 0x21120001 @1; pulse ir_load, then pc_write/pc_sel=0 → ir=0x11230004 two edges after ir_load, pc_out=0x0001; second fetch gives ir=0x21120001.
- **Branch:**
  - pc=0x0010, br_imm=0xFFFE, br_sel=0, pc_sel=1, pc_write=1 → pc_out=0x000F.
  - br_sel=1, br_imm=0x0040 → pc_out=0x0040.
  - pc=0xFFFF, pc_sel=0 → pc_out=0x0000.
- **Timeout:** no ack, TIMEOUT=15 → fetch_err high exactly 1 cycle, 16 cycles after the REQ entry edge; ir=0x00000000, ir_valid=1. An ack arriving afterwards is ignored.
- **PC change mid-fetch:** ir_load at pc=0x0005, then pc_write to 0x0006 during a 4-cycle-latency access → imem_addr stays 0x0005 throughout; ir = data @5; pc_out=0x0006.
- **Reset mid-fetch:** rst_f pulsed in REQ, ack 2 cycles later → imem_req=0 next cycle, ir stays 0, ir_valid stays 0, state IDLE.
